mips_multicycle_ctrl: RTL

Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back over shared PC/IR/ALU/memory resources. Decodes R-type (including JR), LW, SW, BEQ, J, JAL and ADDI. Stalls on a single-port memory ready handshake. Sits between the instruction register and every datapath mux and write-enable.

---
 rtl/mips_multicycle_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath mux and enable.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_code,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] R_EXEC    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] JUMP      = 4'd9;
  localparam logic [3:0] JR        = 4'd10;
  localparam logic [3:0] JAL       = 4'd11;
  localparam logic [3:0] ADDI_EXEC = 4'd12;
  localparam logic [3:0] ADDI_WB   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       illegal_d;

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_op <= illegal_d;
    end
  end

  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:     state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op_code)
          OP_RTYPE:      state_d = (func == FN_JR) ? JR : R_EXEC;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_JAL:        state_d = JAL;
          OP_ADDI:       state_d = ADDI_EXEC;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        if (op_code == OP_LW)      state_d = MEM_READ;
        else if (op_code == OP_SW) state_d = MEM_WRITE;
        else                       state_d = FETCH;
      end
      MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      default:   state_d = FETCH;
    endcase
  end

  // Moore decode; only the FETCH strobes that commit PC/IR wait on memory.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      DECODE:    alu_src_b = 2'b11;
      MEM_ADDR, ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      ADDI_WB:   reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule
